seg7bcd_capture: RTL
====================

# seg7bcd_capture

Scanning seven-segment receiver: samples a time-multiplexed, active-low digit-select/segment bus, as driven to a display by the team's BCD-to-segment encoders and scan logic. It recovers one BCD digit per display position and reports a complete frame once every position has been captured. It sits on the loopback/self-check path next to the display driver. It also serves as a monitor in board bring-up.

## Interface
- `DIGITS`, 8, number of multiplexed display positions (1..8)
- `STABLE_CYCLES`, 4, consecutive identical samples required before a digit is accepted (>=1)

Reset is synchronous and active-low on `rst_n`. The block has one clock, `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `seg_an`  in  DIGITS  digit select, active-low, one-hot-low
- `seg_h`  in  7 (8 with `SEG7_DP_EN`)  segments, active-low; bit6=a, bit5=b … bit0=g; bit7=dp when enabled
- `digits`  out  4*DIGITS  captured BCD; position i in `[4i+3:4i]`
- `digit_err`  out  DIGITS  position i pattern was not a legal 0-9 glyph
- `dp`  out  DIGITS  decimal point per position (only with `SEG7_DP_EN`)
- `frame_valid`  out  1  one-cycle pulse: `digits`/`digit_err`/`dp` just updated

## Operation
- **Input register:** `seg_an` and `seg_h` are registered once; all logic works on the registered copy.
- **Glyph decode (active-low, a..g)**, each pattern maps to its BCD value:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - Any other pattern → value 4'hF with err=1. This includes all-off (1111111).
- **Select legality:** the sample is legal only if exactly one `seg_an` bit is low. Any other select value clears the stability counter and returns the FSM to SETTLE.
- **Per-sample FSM:**
  - SETTLE: count consecutive cycles where the registered {an, h} equals the previous cycle's value. When the count reaches STABLE_CYCLES with a legal select, accept the digit and go to LOCKED.
  - LOCKED: hold until {an, h} changes, then go to SETTLE with the count restarted. A position is never accepted twice in one dwell.
- **Accept:** write value/err (and dp) into shadow slot i, and set seen[i].
  - If the slot was already seen in the current frame, the latest accept overwrites it.
- **Frame completion:** when seen becomes all-ones, shadow slots copy to the outputs, `frame_valid` pulses, and seen clears.
- **Counter:** saturates at STABLE_CYCLES. Width is `$clog2(STABLE_CYCLES+1)`. It does not wrap.

## Timing
- **Reset values:** `digits`=0, `digit_err`=0, `dp`=0, `frame_valid`=0, seen=0, FSM=SETTLE, counter=0, input register=all-ones.
- **Accept latency:** the pattern is sampled at edge E0 and held. Accept occurs at edge E0+STABLE_CYCLES.
- **Frame latency:** the final accept occurs at edge E. Outputs update and `frame_valid`=1 after edge E+1, for exactly one cycle.
- **Simultaneous events:** a frame completion and an accept for the next frame can occur in the same cycle. The new accept lands in the emptied shadow and sets seen for the new frame; it does not corrupt the output copy.
- **Reset mid-dwell or mid-frame:** partial frame is discarded. No `frame_valid` is issued for it.
- **Outputs:** hold their last frame until the next complete frame.

## Configuration
- `SEG7_DP_EN` defined:
  - `seg_h` is 8 bits, and bit7 is dp (active-low).
  - dp is part of the stability comparison but not of glyph legality. It is captured to `dp[i]` (1 = lit).
- Undefined: `seg_h` is 7 bits, and the `dp` port does not exist.

## Test plan
- **Clean frame:** DIGITS=4, STABLE_CYCLES=4. Scan positions 0..3 with glyphs 1,2,3,4, 6 cycles each. Required: `digits`=16'h4321, `digit_err`=0, one `frame_valid` pulse 1 cycle after the position-3 accept.
- **Short dwell:** position 2 held for only 3 cycles. Required: no accept and no frame. Rescanning position 2 for 4+ cycles completes the frame.
- **Illegal glyph:** 7'b1111110 on position 1. Required: slot 1=4'hF, `digit_err`=4'b0010.
- **Bad select:** `seg_an`=4'b1100 held 10 cycles. Required: no accept. The next legal select needs the full STABLE_CYCLES again.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle after 2 positions are accepted. Required: outputs are 0, and the next `frame_valid` comes only after all 4 positions are re-accepted.
- **Decimal point (`SEG7_DP_EN`):** glyph 7 with dp lit on position 0. Required: slot 0=7, `dp[0]`=1.

Source files
------------

// File: rtl/seg7bcd_capture.sv
// seg7bcd_capture: recovers BCD digits from a scanned, active-low
// digit-select/segment bus and reports each complete display frame.
//
// Parameters: DIGITS (positions, 1..8), STABLE_CYCLES (dwell to accept).
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   seg_an        digit select, active-low, one-hot-low
//   seg_h         segments a..g active-low (bit6=a .. bit0=g), bit7=dp
//                 when SEG7_DP_EN is defined
//   digits        captured BCD, position i at [4i+3:4i]
//   digit_err     position i held an illegal glyph
//   dp            decimal point per position (SEG7_DP_EN only)
//   frame_valid   one-cycle pulse when the outputs take a new frame
// Build option: define SEG7_DP_EN to add decimal-point capture.
module seg7bcd_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS-1:0]   seg_an,
`ifdef SEG7_DP_EN
    input  logic [7:0]          seg_h,
    output logic [DIGITS-1:0]   dp,
`else
    input  logic [6:0]          seg_h,
`endif
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   digit_err,
    output logic                frame_valid
);

`ifdef SEG7_DP_EN
    localparam int HW = 8;
`else
    localparam int HW = 7;
`endif
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW:0] SC = (CW+1)'(STABLE_CYCLES);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [DIGITS-1:0]   an_q, an_p;
    logic [HW-1:0]       h_q, h_p;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW:0]         run;
    logic                same, legal, settling, accept;
    logic [4:0]          dec;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_err, seen, seen_d;
    logic                full;

    function automatic logic [4:0] glyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001111: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    assign dec   = glyph(h_q[6:0]);
    assign same  = (an_q == an_p) && (h_q == h_p);
    assign legal = $onehot(~an_q);
    assign full  = &seen;

    // run = cycles the current registered sample has been held,
    // including this one; one wider than the counter so it never wraps.
    assign run = same ? ({1'b0, cnt_q} + (CW+1)'(1)) : (CW+1)'(1);

    // A change while LOCKED starts a new dwell straight away.
    assign settling = (state_q == SETTLE) || !same;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!legal) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else begin
            cnt_d = (run >= SC) ? SC[CW-1:0] : run[CW-1:0];
            if (settling && (run >= SC)) begin
                accept  = 1'b1;
                state_d = LOCKED;
            end else if (!same) begin
                state_d = SETTLE;
            end
        end
    end

    // Completion empties the shadow; a coincident accept starts the
    // next frame in the emptied set.
    always_comb begin
        seen_d = full ? '0 : seen;
        if (accept)
            seen_d = seen_d | ~an_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q    <= '1;
            h_q     <= '1;
            an_p    <= '1;
            h_p     <= '1;
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            an_q    <= seg_an;
            h_q     <= seg_h;
            an_p    <= an_q;
            h_p     <= h_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_val      <= '0;
            sh_err      <= '0;
            seen        <= '0;
            digits      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            seen        <= seen_d;
            frame_valid <= full;
            if (full) begin
                digits    <= sh_val;
                digit_err <= sh_err;
            end
            for (int k = 0; k < DIGITS; k++) begin
                if (accept && !an_q[k]) begin
                    sh_val[4*k +: 4] <= dec[3:0];
                    sh_err[k]        <= dec[4];
                end
            end
        end
    end

`ifdef SEG7_DP_EN
    logic [DIGITS-1:0] sh_dp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_dp <= '0;
            dp    <= '0;
        end else begin
            if (full)
                dp <= sh_dp;
            for (int k = 0; k < DIGITS; k++) begin
                if (accept && !an_q[k])
                    sh_dp[k] <= ~h_q[7];
            end
        end
    end
`endif

endmodule
